calc_core: RTL

Iterative signed multiply core that consumes the parameter pair loaded from the input pins and streams the 64-bit product back out byte-serially. It sits directly downstream of the parameter loader. It takes `a0`, `a1` and `start_calc` from the loader and drives back the `core_busy` signal the loader waits on. It computes `a0 * a1` with a 32-step shift-add algorithm, then presents the result on an 8-bit output port, LSB byte first.

---
 rtl/calc_core.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/calc_core.sv
`default_nettype none
// ============================================================================
//  Module      : calc_core
//  Description : Iterative signed 32x32 multiply (32-step shift-add on
//                magnitudes, sign applied once) with byte-serial output of
//                the 64-bit product, LSB byte first.
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic        start_calc,
  output logic        core_busy,
  output logic [63:0] result,
  output logic [7:0]  out_pins,
  output logic        out_valid,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  localparam logic [4:0] c_LAST_STEP = 5'd31;
  localparam logic [2:0] c_LAST_BYTE = 3'd7;

  // Registered state
  state_t      r_state;
  logic        r_start_d;
  logic [31:0] r_mag_a;
  logic [31:0] r_mag_b;
  logic        r_neg;
  logic [63:0] r_acc;
  logic [4:0]  r_step;
  logic [2:0]  r_byte_idx;
  logic        r_busy;
  logic [63:0] r_result;
  logic        r_done;

  // Next-state values
  state_t      w_state;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic        w_neg;
  logic [63:0] w_acc;
  logic [4:0]  w_step;
  logic [2:0]  w_byte_idx;
  logic        w_busy;
  logic [63:0] w_result;
  logic        w_done;

  // Helpers
  logic        w_start;
  logic [31:0] w_abs_a0;
  logic [31:0] w_abs_a1;
  logic [63:0] w_addend;

  // Rising edge of the loader request, only honoured while idle
  assign w_start  = (r_state == S_IDLE) && start_calc && !r_start_d;

  // Magnitudes; |-2^31| wraps to 0x8000_0000, which is the correct unsigned value
  assign w_abs_a0 = a0[31] ? (~a0 + 32'd1) : a0;
  assign w_abs_a1 = a1[31] ? (~a1 + 32'd1) : a1;

  // Partial product for the current step
  assign w_addend = {32'b0, r_mag_a} << r_step;

  // Next-state and datapath decisions; every target defaults to holding
  always_comb begin
    w_state    = r_state;
    w_mag_a    = r_mag_a;
    w_mag_b    = r_mag_b;
    w_neg      = r_neg;
    w_acc      = r_acc;
    w_step     = r_step;
    w_byte_idx = r_byte_idx;
    w_busy     = r_busy;
    w_result   = r_result;
    w_done     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_mag_a = w_abs_a0;
          w_mag_b = w_abs_a1;
          w_neg   = a0[31] ^ a1[31];
          w_acc   = 64'd0;
          w_step  = 5'd0;
          w_busy  = 1'b1;
          w_state = S_MUL;
        end
      end

      S_MUL: begin
        if (r_mag_b[0]) begin
          w_acc = r_acc + w_addend;
        end
        w_mag_b = r_mag_b >> 1;
        w_step  = r_step + 5'd1;
        if (r_step == c_LAST_STEP) begin
          w_state = S_FIX;
        end
      end

      S_FIX: begin
        w_result   = r_neg ? (~r_acc + 64'd1) : r_acc;
        w_byte_idx = 3'd0;
        w_state    = S_OUT;
      end

      S_OUT: begin
        w_byte_idx = r_byte_idx + 3'd1;
        if (r_byte_idx == c_LAST_BYTE) begin
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = S_IDLE;
        end
      end

      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State register: async clear, everything frozen while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_start_d  <= 1'b0;
      r_mag_a    <= 32'd0;
      r_mag_b    <= 32'd0;
      r_neg      <= 1'b0;
      r_acc      <= 64'd0;
      r_step     <= 5'd0;
      r_byte_idx <= 3'd0;
      r_busy     <= 1'b0;
      r_result   <= 64'd0;
      r_done     <= 1'b0;
    end else if (ena) begin
      r_state    <= w_state;
      r_start_d  <= start_calc;
      r_mag_a    <= w_mag_a;
      r_mag_b    <= w_mag_b;
      r_neg      <= w_neg;
      r_acc      <= w_acc;
      r_step     <= w_step;
      r_byte_idx <= w_byte_idx;
      r_busy     <= w_busy;
      r_result   <= w_result;
      r_done     <= w_done;
    end
  end

  // Output byte is a pure decode of registered state, so it clears with reset
  assign out_valid = (r_state == S_OUT);
  assign out_pins  = out_valid ? r_result[{r_byte_idx, 3'b000} +: 8] : 8'd0;
  assign core_busy = r_busy;
  assign result    = r_result;
  assign done      = r_done;

endmodule
`default_nettype wire
